// File: rtl/fifo_ctrl_param_pkg.sv
// fifo_pkg: shared types and helpers for the parametrised FIFO controller.
//   fifo_addr_w()  - address width for a given depth
//   fifo_lvl_w()   - pointer/level width (one extra bit to tell full from empty)
//   fifo_status_t  - bundle of status flags as driven onto the bus
//   ERR_*          - bit positions inside the sticky error register
package fifo_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_W   = 2;

    function automatic int fifo_addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int fifo_lvl_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ctrl_param_if.sv
// fifo_ctrl_param_if: producer/consumer bus of the FIFO controller.
//   slave  - FIFO side: receives push/pop/flush/clear, drives data and status
//   master - user side: drives requests, observes data and status
interface fifo_ctrl_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int LVL_W = fifo_lvl_w(DEPTH);

    logic              i_flush;
    logic              i_push;
    logic [DATA_W-1:0] in_data;
    logic              i_pop;
    logic              i_clr_err;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              is_empty;
    logic              is_full;
    logic              is_almost_full;
    logic              is_almost_empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    modport slave (
        input  i_flush, i_push, in_data, i_pop, i_clr_err,
        output out_data, out_valid, is_empty, is_full, is_almost_full,
               is_almost_empty, level, overflow, underflow
    );

    modport master (
        output i_flush, i_push, in_data, i_pop, i_clr_err,
        input  out_data, out_valid, is_empty, is_full, is_almost_full,
               is_almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_ctrl_param_ram.sv
// fifo_ram: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
module fifo_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read before write: a same-cycle write to the read slot is seen next cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: parametrised single-clock FIFO with occupancy level,
// almost-full/almost-empty thresholds, optional first-word-fall-through and
// sticky overflow/underflow flags.
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - fifo_ctrl_param_if.slave: requests in, data/status out
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_ctrl_param_if.slave      bus
);

    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int PTR_W  = fifo_lvl_w(DEPTH);

    if (DATA_W < 1) begin : g_bad_width
        $error("fifo_ctrl_param: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_ctrl_param: DEPTH must be a power of two >= 2");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("fifo_ctrl_param: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  lvl;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_nxt;
    logic              pop_ok;
    logic              push_ok;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    fifo_status_t      st;

    assign lvl = wr_ptr - rd_ptr;

    // Full: same slot, different lap.
    assign st.empty        = (wr_ptr == rd_ptr);
    assign st.full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                             (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign st.almost_full  = (lvl >= PTR_W'(AF_THRESH));
    assign st.almost_empty = (lvl <= PTR_W'(AE_THRESH));
    assign st.overflow     = err_q[ERR_OVF];
    assign st.underflow    = err_q[ERR_UNF];

    // A pop frees the slot, so a push while full is still accepted.
    assign pop_ok  = bus.i_pop & ~st.empty;
    assign push_ok = bus.i_push & (~st.full | pop_ok);
    assign ram_we  = push_ok & ~bus.i_flush & ~rst;

    always_comb begin
        err_nxt = err_q;
        if (bus.i_clr_err) begin
            err_nxt = '0;
        end
        // A fresh error beats the clear in the same cycle.
        if (bus.i_push & ~push_ok) begin
            err_nxt[ERR_OVF] = 1'b1;
        end
        if (bus.i_pop & ~pop_ok) begin
            err_nxt[ERR_UNF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_q  <= '0;
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            err_q <= err_nxt;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT) begin : g_fwft
        // Head word is presented directly; popping advances to the next word.
        assign bus.out_data  = ram_rdata;
        assign bus.out_valid = ~st.empty;
    end else begin : g_reg_rd
        logic [DATA_W-1:0] out_data_q;
        logic              out_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else if (bus.i_flush) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= pop_ok;
                if (pop_ok) begin
                    out_data_q <= ram_rdata;
                end
            end
        end

        assign bus.out_data  = out_data_q;
        assign bus.out_valid = out_valid_q;
    end

    assign bus.is_empty        = st.empty;
    assign bus.is_full         = st.full;
    assign bus.is_almost_full  = st.almost_full;
    assign bus.is_almost_empty = st.almost_empty;
    assign bus.overflow        = st.overflow;
    assign bus.underflow       = st.underflow;
    assign bus.level           = lvl;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
module tb_fifo_ctrl_param;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int AF_TH  = 6;
    localparam int AE_TH  = 2;

    logic clk;
    logic rst;

    int n_chk = 0;
    int n_bad = 0;

    logic [15:0] mq [$];
    logic [15:0] sb [$];
    bit          m_ovf;
    bit          m_unf;

    fifo_ctrl_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) f0 ();
    fifo_ctrl_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) f1 ();

    fifo_ctrl_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_TH), .AE_THRESH(AE_TH), .FWFT(1'b0)
    ) u_dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (f0)
    );

    fifo_ctrl_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_TH), .AE_THRESH(AE_TH), .FWFT(1'b1)
    ) u_dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock on the registered-read FIFO, with the model stepped alongside.
    task automatic step(input logic push, input logic [15:0] d, input logic pop,
                        input logic flush, input logic clr);
        bit pop_ok;
        bit push_ok;
        int lvl;
        lvl     = mq.size();
        pop_ok  = pop && (lvl != 0) && !flush;
        push_ok = push && ((lvl < DEPTH) || pop_ok) && !flush;
        if (flush) begin
            mq.delete();
        end else begin
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (push && !push_ok) m_ovf = 1'b1;
            if (pop && !pop_ok)   m_unf = 1'b1;
        end
        if (pop_ok)  sb.push_back(mq.pop_front());
        if (push_ok) mq.push_back(d);

        f0.i_push    = push;
        f0.in_data   = d;
        f0.i_pop     = pop;
        f0.i_flush   = flush;
        f0.i_clr_err = clr;
        @(posedge clk);
        #1;
        f0.i_push    = 1'b0;
        f0.i_pop     = 1'b0;
        f0.i_flush   = 1'b0;
        f0.i_clr_err = 1'b0;

        lvl = mq.size();
        chk("out_valid", 32'(f0.out_valid), 32'(pop_ok));
        if (pop_ok && sb.size() > 0) chk("rd_data", 32'(f0.out_data), 32'(sb.pop_front()));
        chk("level", 32'(f0.level), 32'(lvl));
        chk("is_empty", 32'(f0.is_empty), 32'(lvl == 0));
        chk("is_full", 32'(f0.is_full), 32'(lvl == DEPTH));
        chk("almost_full", 32'(f0.is_almost_full), 32'(lvl >= AF_TH));
        chk("almost_empty", 32'(f0.is_almost_empty), 32'(lvl <= AE_TH));
        chk("overflow", 32'(f0.overflow), 32'(m_ovf));
        chk("underflow", 32'(f0.underflow), 32'(m_unf));
    endtask

    task automatic f1_cycle(input logic push, input logic [15:0] d, input logic pop,
                            input logic flush);
        f1.i_push  = push;
        f1.in_data = d;
        f1.i_pop   = pop;
        f1.i_flush = flush;
        @(posedge clk);
        #1;
        f1.i_push  = 1'b0;
        f1.i_pop   = 1'b0;
        f1.i_flush = 1'b0;
    endtask

    initial begin
        f0.i_push = 0; f0.in_data = '0; f0.i_pop = 0; f0.i_flush = 0; f0.i_clr_err = 0;
        f1.i_push = 0; f1.in_data = '0; f1.i_pop = 0; f1.i_flush = 0; f1.i_clr_err = 0;
        m_ovf = 0;
        m_unf = 0;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(f0.is_empty), 32'd1);
        chk("rst_level", 32'(f0.level), 32'd0);
        chk("rst_ae", 32'(f0.is_almost_empty), 32'd1);
        chk("rst_af", 32'(f0.is_almost_full), 32'd0);
        chk("rst_full", 32'(f0.is_full), 32'd0);
        chk("rst_valid", 32'(f0.out_valid), 32'd0);
        chk("rst_data", 32'(f0.out_data), 32'd0);
        chk("rst_ovf", 32'(f0.overflow), 32'd0);
        chk("rst_unf", 32'(f0.underflow), 32'd0);
        chk("rst_f1_valid", 32'(f1.out_valid), 32'd0);
        rst = 1'b0;

        // Fill past full, then drain
        for (int i = 1; i <= 9; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Push and pop together while full
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Push and pop together while empty
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Steady level 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 16'h6000 + 16'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

        // Flush with push held high
        step(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("sb_left", 32'(sb.size()), 32'd0);

        // First-word-fall-through instance
        f1_cycle(1'b1, 16'h00A5, 1'b0, 1'b0);
        chk("fwft_valid", 32'(f1.out_valid), 32'd1);
        chk("fwft_data", 32'(f1.out_data), 32'h00A5);
        f1_cycle(1'b1, 16'h00B6, 1'b0, 1'b0);
        chk("fwft_head_hold", 32'(f1.out_data), 32'h00A5);
        chk("fwft_level2", 32'(f1.level), 32'd2);
        f1_cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("fwft_next", 32'(f1.out_data), 32'h00B6);
        chk("fwft_level1", 32'(f1.level), 32'd1);
        f1_cycle(1'b1, 16'h5A5A, 1'b0, 1'b1);
        chk("fwft_flush_lvl", 32'(f1.level), 32'd0);
        chk("fwft_flush_valid", 32'(f1.out_valid), 32'd0);
        chk("fwft_flush_ovf", 32'(f1.overflow), 32'd0);
        f1_cycle(1'b0, 16'h0, 1'b0, 1'b0);
        chk("fwft_discard", 32'(f1.is_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
